// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, fully oversampled on clk (nothing runs on sclk).
// Receives words on mosi and returns words from a one-deep valid/ready TX buffer.
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_abort
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_d1_q, ss_d1_q;
  logic                   sclk_s, mosi_s, ss_n_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_d1_q   <= 1'b0;
      ss_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      sclk_d1_q   <= sclk_s;
      ss_d1_q     <= ss_n_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_n_s    = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s &  sclk_d1_q;
  assign ss_fall   = ~ss_n_s &  ss_d1_q;
  assign ss_rise   =  ss_n_s & ~ss_d1_q;

  // The word's MSB lives in miso_q, so the shifters only hold the other bits.
  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  word_done_q, word_done_d;
  logic [DATA_WIDTH-2:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] txbuf_q, txbuf_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  frame_abort_q, frame_abort_d;
  logic                  miso_q, miso_d;
  logic                  miso_en_q, miso_en_d;
  logic                  load;
  logic [DATA_WIDTH-1:0] rx_next, load_word;

  assign rx_next   = {rx_shift_q, mosi_s};
  assign load_word = tx_ready_q ? IDLE_WORD : txbuf_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_done_d   = word_done_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    txbuf_d       = txbuf_q;
    tx_ready_d    = tx_ready_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    miso_d        = miso_q;
    miso_en_d     = miso_en_q;
    load          = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_en_d = 1'b0;
        if (ss_fall) begin
          state_d     = SHIFT;
          load        = 1'b1;
          miso_en_d   = 1'b1;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          word_done_d = 1'b0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d       = IDLE;
          miso_en_d     = 1'b0;
          miso_d        = 1'b0;
          word_done_d   = 1'b0;
          frame_abort_d = (bit_cnt_q != '0);
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_next[DATA_WIDTH-2:0];
            if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
              rx_data_d   = rx_next;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (sclk_fall) begin
            if (word_done_q) begin
              load        = 1'b1;
              word_done_d = 1'b0;
            end else begin
              miso_d     = tx_shift_q[DATA_WIDTH-2];
              tx_shift_d = {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Load sees the pre-write buffer; a same-cycle write stays buffered.
    if (load) begin
      miso_d        = load_word[DATA_WIDTH-1];
      tx_shift_d    = load_word[DATA_WIDTH-2:0];
      tx_underrun_d = tx_ready_q;
      tx_ready_d    = 1'b1;
    end
    if (tx_valid && tx_ready_q) begin
      txbuf_d    = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      word_done_q   <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      txbuf_q       <= '0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_done_q   <= word_done_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      txbuf_q       <= txbuf_d;
      tx_ready_q    <= tx_ready_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
      miso_q        <= miso_d;
      miso_en_q     <= miso_en_d;
    end
  end

  assign miso        = miso_q;
  assign miso_en     = miso_en_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;
endmodule
